// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus seen by the UART transmitter: core stores/loads plus the
// window-select flag used by top-level read muxing.
interface mmio_uart_tx_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;

  modport master (output we, a, wd, input rd, sel);
  modport slave  (input we, a, wd, output rd, sel);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and programmable divisor.
// Define UART_TX_PARITY_EN to add a parity bit (DIVISOR[16] selects odd parity).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic             clk,
  input  logic             reset,
  mmio_uart_tx_if.slave    bus,
  output logic             tx,
  output logic             irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg, state_next;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            overrun_reg;
  logic [15:0]     div_reg;
  logic [15:0]     frame_div_reg, frame_div_next;
  logic [15:0]     cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;
  logic            irq_reg;
`ifdef UART_TX_PARITY_EN
  logic            odd_reg;
  logic            frame_odd_reg, frame_odd_next;
`endif

  logic        sel_hit, wr_en, push_req, status_wr, div_wr;
  logic [1:0]  idx;
  logic        fifo_empty, fifo_full, push_ok, overrun_set, pop, start_frame, busy, bit_end;
  logic [7:0]  head;
  logic [31:0] rd_data;

  assign sel_hit    = (bus.a[31:4] == BASE_ADDR[31:4]);
  assign idx        = bus.a[3:2];
  assign wr_en      = bus.we & sel_hit;
  assign push_req   = wr_en & (idx == 2'd0);
  assign status_wr  = wr_en & (idx == 2'd1);
  assign div_wr     = wr_en & (idx == 2'd2);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_COUNT);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok     = push_req & (~fifo_full | pop);
  assign overrun_set = push_req & fifo_full & ~pop;
  assign head        = fifo_mem[rd_ptr_reg];
  assign busy        = (state_reg != IDLE);
  assign bit_end     = (cnt_reg == frame_div_reg - 16'd1);

`ifdef UART_TX_PARITY_EN
  logic unused_bits;
  assign unused_bits = ^{bus.a[1:0], bus.wd[31:17]};
`else
  logic unused_bits;
  assign unused_bits = ^{bus.a[1:0], bus.wd[31:16]};
`endif

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr_reg] <= bus.wd[7:0];
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    frame_div_next = frame_div_reg;
    tx_next        = tx_reg;
    pop            = 1'b0;
    start_frame    = 1'b0;
`ifdef UART_TX_PARITY_EN
    frame_odd_next = frame_odd_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty)
          start_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          cnt_next     = '0;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = (^shift_reg) ^ frame_odd_reg;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[bit_idx_reg + 3'd1];
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          cnt_next   = '0;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
            tx_next    = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Divisor (and parity sense) are frozen per frame so mid-frame writes wait.
    if (start_frame) begin
      pop            = 1'b1;
      shift_next     = head;
      state_next     = START;
      cnt_next       = '0;
      tx_next        = 1'b0;
      frame_div_next = div_reg;
`ifdef UART_TX_PARITY_EN
      frame_odd_next = odd_reg;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overrun_reg   <= 1'b0;
      div_reg       <= DIV_RESET;
      frame_div_reg <= DIV_RESET;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= 1'b1;
      irq_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      odd_reg       <= 1'b0;
      frame_odd_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      frame_div_reg <= frame_div_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      irq_reg       <= (count_next == '0) && (state_next == IDLE);
`ifdef UART_TX_PARITY_EN
      frame_odd_reg <= frame_odd_next;
`endif
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (overrun_set)
        overrun_reg <= 1'b1;
      else if (status_wr && bus.wd[0])
        overrun_reg <= 1'b0;
      if (div_wr) begin
        div_reg <= (bus.wd[15:0] == 16'd0) ? 16'd1 : bus.wd[15:0];
`ifdef UART_TX_PARITY_EN
        odd_reg <= bus.wd[16];
`endif
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel_hit) begin
      case (idx)
        2'd1: rd_data = {28'b0, busy, fifo_empty, fifo_full, overrun_reg};
        2'd2: begin
          rd_data[15:0] = div_reg;
`ifdef UART_TX_PARITY_EN
          rd_data[16] = odd_reg;
`endif
        end
        default: rd_data = '0;
      endcase
    end
  end

  assign bus.rd  = rd_data;
  assign bus.sel = sel_hit;
  assign tx      = tx_reg;
  assign irq     = irq_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: expected serial streams come from a
// frame-level model (bit lists per byte), not from the RTL's state machine.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic tx, irq;
  int   checks = 0;
  int   errors = 0;
  bit   parity_odd = 1'b0;
  logic [15:0] exp_div = 16'd16;
  logic [7:0]  tx_bytes[$];
  bit          exp_q[$];

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .irq(irq));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serial image of one frame: start, data LSB first, optional parity, stop.
  function automatic void add_frame(input logic [7:0] data, input int div);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^data) ^ parity_odd);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) repeat (div) exp_q.push_back(bits[k]);
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.we = 1'b1; bus.a = addr; bus.wd = data;
    @(posedge clk);
    #1 bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.a = addr;
    #1 data = bus.rd;
  endtask

  task automatic check_reg(input string name, input logic [31:0] addr, input logic [31:0] want);
    logic [31:0] got;
    bus_read(addr, got);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: rd=%h expected %h", name, got, want);
    end else $display("ok   %s: rd=%h", name, got);
  endtask

  task automatic write_div(input logic [31:0] w);
    bus_write(BASE + 8, w);
    exp_div = (w[15:0] == 16'd0) ? 16'd1 : w[15:0];
`ifdef UART_TX_PARITY_EN
    parity_odd = w[16];
`endif
    check_reg("divisor_readback", BASE + 8, {15'b0, parity_odd, exp_div});
  endtask

  // Pushes tx_bytes on consecutive edges while checking tx from the edge after the first push.
  task automatic send_and_check(input string name, input int div);
    int npush, accepted;
    logic [31:0] st_exp;
    npush    = tx_bytes.size();
    // All pushes land inside the first frame, so only the shifter plus FIFO can hold them.
    accepted = (npush > DEPTH + 1) ? DEPTH + 1 : npush;
    exp_q.delete();
    for (int i = 0; i < accepted; i++) add_frame(tx_bytes[i], div);
    st_exp = {28'b0, 1'b1, accepted == 1, (accepted - 1) == DEPTH, npush > DEPTH + 1};
    fork
      begin
        for (int i = 0; i < npush; i++) begin
          @(negedge clk);
          bus.we = 1'b1; bus.a = BASE; bus.wd = {24'($urandom), tx_bytes[i]};
          @(posedge clk);
        end
        #1 bus.we = 1'b0;
      end
      begin
        bit bad;
        logic [31:0] st;
        bad = 1'b0;
        @(negedge clk);
        @(posedge clk);
        checks++;
        for (int j = 0; j < exp_q.size(); j++) begin
          @(posedge clk);
          #2;
          if (!bad && tx !== exp_q[j]) begin
            bad = 1'b1;
            errors++;
            $display("FAIL %s stream: tx[%0d]=%b expected %b", name, j, tx, exp_q[j]);
          end
          if (j == npush) begin
            bus_read(BASE + 4, st);
            checks++;
            if (st !== st_exp || irq !== 1'b0) begin
              errors++;
              $display("FAIL %s mid-frame status: rd=%h irq=%b expected %h irq=0", name, st, irq, st_exp);
            end
          end
        end
        @(posedge clk);
        #2;
        checks++;
        if (tx !== 1'b1 || irq !== 1'b1) begin
          errors++;
          $display("FAIL %s end-of-stream: tx=%b irq=%b expected tx=1 irq=1", name, tx, irq);
        end
        $display("ok   %s: %0d frames, %0d clocks checked", name, accepted, exp_q.size());
      end
    join
  endtask

  task automatic watch_idle(input string name, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #2;
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL %s: tx low for %0d clocks, expected 0", name, lows);
    end else $display("ok   %s: tx idle for %0d clocks", name, cycles);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.we = 1'b0; bus.a = '0; bus.wd = '0;
    #1;
    checks++;
    if (tx !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b irq=%b expected 1 1", tx, irq);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check_reg("reset_status", BASE + 4, 32'h4);
    checks++;
    if (bus.sel !== 1'b1 || tx !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL reset_sel_tx_irq: sel=%b tx=%b irq=%b expected 1 1 1", bus.sel, tx, irq);
    end
    check_reg("reset_reserved", BASE + 12, 32'h0);
    check_reg("reset_divisor", BASE + 8, 32'd16);
    check_reg("txdata_reads_zero", BASE + 0, 32'h0);
  endtask

  task automatic test_single_frame();
    write_div(32'h0000_0004);
    tx_bytes = {};
    tx_bytes.push_back(8'h55);
    send_and_check("frame_55_div4", 4);
    write_div(32'hABCD_0004);
    for (int r = 0; r < 3; r++) begin
      int div;
      div = $urandom_range(1, 6);
      write_div(32'(div));
      tx_bytes = {};
      tx_bytes.push_back(8'($urandom));
      send_and_check("frame_random", div);
    end
  endtask

  task automatic test_back_to_back();
    write_div(32'd16);
    tx_bytes = {};
    for (int i = 0; i < 6; i++) tx_bytes.push_back(8'($urandom));
    send_and_check("back_to_back_overrun", 16);
    check_reg("overrun_sticky", BASE + 4, 32'h5);
    bus_write(BASE + 4, 32'hFFFF_FFFE);
    check_reg("status_ro_bits", BASE + 4, 32'h5);
    bus_write(BASE + 4, 32'h1);
    check_reg("overrun_cleared", BASE + 4, 32'h4);
  endtask

  task automatic test_div_zero();
    write_div(32'h0);
    tx_bytes = {};
    tx_bytes.push_back(8'hFF);
    send_and_check("frame_ff_div1", 1);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    write_div(32'd4);
    b = 8'($urandom) & 8'hF7;
    bus_write(BASE, {24'h0, b});
    repeat (17) @(posedge clk);
    #2;
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL data_bit3_before_reset: tx=%b expected 0", tx);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: tx=%b irq=%b expected 1 1", tx, irq);
    end else $display("ok   async_reset: tx forced high mid-cycle");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    parity_odd = 1'b0;
    exp_div = 16'd16;
    check_reg("post_reset_status", BASE + 4, 32'h4);
    check_reg("post_reset_divisor", BASE + 8, 32'd16);
    watch_idle("post_reset_no_frames", 60);
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    bus.we = 1'b1; bus.a = BASE + 16; bus.wd = {24'($urandom), 8'h00};
    #1;
    checks++;
    if (bus.sel !== 1'b0 || bus.rd !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_decode: sel=%b rd=%h expected 0 0", bus.sel, bus.rd);
    end
    @(posedge clk);
    #1 bus.we = 1'b0;
    check_reg("below_window", BASE - 4, 32'h0);
    watch_idle("unmapped_no_push", 30);
    check_reg("unmapped_status", BASE + 4, 32'h4);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    write_div(32'h0000_0003);
    tx_bytes = {};
    tx_bytes.push_back(8'h07);
    send_and_check("parity_even_07", 3);
    write_div(32'h0001_0005);
    tx_bytes = {};
    tx_bytes.push_back(8'($urandom));
    send_and_check("parity_odd_random", 5);
    write_div(32'd16);
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_div_zero();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_unmapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that responds to the core's data-memory bus (we, a, wd, rd), using the same word-addressed protocol as the data RAM. The core issues stores and loads; this block is the responder. Bytes the core stores into TXDATA go into a small FIFO. The block then serialises them as 8N1 frames on tx, with a programmable clocks-per-bit divisor. It sits beside dmem; top-level logic uses sel to choose this block's rd over the RAM's.

Parameters:
- BASE_ADDR, 32'h0000_0100: byte base address of the 16-byte register window; must be 16-byte aligned.
- FIFO_DEPTH, 4: TX FIFO entries; power of 2, minimum 2.
- DIV_RESET, 16'd16: reset value of DIVISOR (clocks per serial bit).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- we  in  1  bus write enable (the core's MemWrite).
- a  in  32  bus byte address (the core's DataAdr).
- wd  in  32  bus write data.
- rd  out  32  bus read data, combinational.
- sel  out  1  combinational; 1 when a[31:4] == BASE_ADDR[31:4].
- tx  out  1  serial output, registered; idle high.
- irq  out  1  registered level; 1 when FIFO empty and transmitter idle.

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-frame. Reset values:
  - tx=1, irq=1.
  - FIFO empty, FSM in IDLE, overrun=0, DIVISOR=DIV_RESET.
  - rd and sel follow a; they are combinational.
- Register map, selected by a[3:2] when sel=1; a[1:0] ignored:
  - 0 TXDATA: write pushes wd[7:0]. Reads 0.
  - 1 STATUS: read {28'b0, busy, empty, full, overrun}. Writing wd[0]=1 clears overrun; other bits read-only.
  - 2 DIVISOR: R/W on [15:0]; upper bits read 0. A write of 0 is stored as 1.
  - 3 reserved: reads 0, writes ignored.
- When sel=0: rd=0 and writes are ignored.
- Register writes occur on the posedge where we=1 and sel=1. Reads are same-cycle combinational, matching dmem timing.
- FIFO push when full: data is dropped and overrun is set; overrun is sticky.
- Push and pop on the same edge while full: the push is accepted and overrun is not set.
- FSM states: IDLE, START, DATA, STOP. Each bit lasts exactly DIVISOR clocks. DIVISOR is latched into a frame-local register on entry to START; a mid-frame write affects only the next frame.
- IDLE: tx=1. If the FIFO is non-empty at an edge, pop the head into the shift register, go to START, and drive tx=0.
- Push-to-start latency: a byte pushed at edge N while idle drives tx low from edge N+1.
- DATA: 8 bits, LSB first. A bit counter counts 0..7; after bit 7, go to STOP.
- STOP: tx=1 for one bit time. At the end of STOP:
  - FIFO non-empty: pop and go straight to START (back-to-back frames, no idle gap).
  - Otherwise: go to IDLE.
- Frame length: 10*DIVISOR clocks.
- Status and interrupt:
  - busy = (state != IDLE).
  - empty and full reflect FIFO occupancy; pointers wrap modulo FIFO_DEPTH, with a count of 0..FIFO_DEPTH.
  - irq is registered from empty & ~busy of the next state.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, giving 11-bit frames of 11*DIVISOR clocks.
  - DIVISOR bit 16 is R/W: 0 = even parity, 1 = odd parity. Reset value 0.
  - Parity bit = ^data XOR DIVISOR[16].
- Undefined:
  - No PARITY state.
  - Bit 16 reads 0 and writes to it are ignored.

Test Plan:
1. Assert reset, release it, read a=BASE+4 -> rd=32'h4, tx=1, irq=1, sel=1. Read a=BASE+12 -> rd=0.
2. Write DIVISOR=4, then write 0x55 to TXDATA at edge N -> tx=0 for cycles N+1..N+4. Then bit pattern 1,0,1,0,1,0,1,0, each 4 clocks. Then stop bit high for 4 clocks. irq rises 40 clocks after N+1. STATUS busy=1 during the frame.
3. With DIVISOR=16, write 6 bytes on 6 consecutive cycles -> 5 accepted (1 in the shifter, 4 in the FIFO); the 6th sets overrun, so STATUS=32'hB. Exactly 5 frames go out with no idle gap, 800 clocks total. Then write STATUS wd=1 -> overrun=0.
4. Write DIVISOR=0 -> readback is 1; a 0xFF frame shows tx low for exactly 1 clock, then high.
5. Assert reset during DATA bit 3 -> tx=1 in the same cycle (asynchronous). After release, STATUS=32'h4, DIVISOR reads 16, and no further frames are sent.
6. Write to a=BASE+16 -> sel=0, rd=0, no push, tx stays 1. Under UART_TX_PARITY_EN, byte 0x07 with even parity -> parity bit=1 and the frame is 11*DIVISOR clocks.
